// File: rtl/lc3_pkg.sv
// LC-3 decode constants and immediate sign-extension helpers shared by the ID stage.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package lc3_pkg;

    // Widest data path the helpers cover; callers cast the result down to their DW.
    localparam int XW = 64;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_EXC  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    // Sub-functions sharing opcode 1001, selected by ir[5:0]:
    //   111111 NOT, 100001 DPS (read psr), 00xxxx LS / 01xxxx RS (imm4 in ir[3:0]).
    // Any other ir[5:0] under 1001 is undefined.
    localparam logic [5:0] FN_NOT = 6'b111111;
    localparam logic [5:0] FN_DPS = 6'b100001;

    // Alias for the 1001 group when it is read as a whole.
    localparam logic [3:0] OP_ALU1 = OP_NOT;

    function automatic logic [XW-1:0] sext_imm5(input logic [4:0] v);
        return {{(XW-5){v[4]}}, v};
    endfunction

    function automatic logic [XW-1:0] sext_off6(input logic [5:0] v);
        return {{(XW-6){v[5]}}, v};
    endfunction

    function automatic logic [XW-1:0] sext_off9(input logic [8:0] v);
        return {{(XW-9){v[8]}}, v};
    endfunction

    function automatic logic [XW-1:0] sext_off11(input logic [10:0] v);
        return {{(XW-11){v[10]}}, v};
    endfunction

endpackage

// File: rtl/lc3_fwd_mux.sv
// Per-source operand select (EX > MEM > register file) and load-use / match hazard flag.
// Latency: combinational.
// Backpressure: raises hazard so the stage withholds in_ready; never stores data.
module lc3_fwd_mux
    import lc3_pkg::*;
#(
    parameter int DW     = 16,
    parameter bit FWD_EN = 1'b1
) (
    input  logic          use_src,
    input  logic [2:0]    src,
    input  logic [DW-1:0] rf_dat,
    input  logic          ex_wen,
    input  logic          ex_load,
    input  logic [2:0]    ex_dst,
    input  logic [DW-1:0] ex_data,
    input  logic          mem_wen,
    input  logic [2:0]    mem_dst,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] src_dat,
    output logic          hazard
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = ex_wen  && (ex_dst  == src);
    assign mem_hit = mem_wen && (mem_dst == src);

    // Pick the youngest producer; without forwarding any in-flight writer stalls instead.
    always_comb begin
        src_dat = rf_dat;
        hazard  = 1'b0;
        if (FWD_EN) begin
            if (ex_hit) begin
                src_dat = ex_data;
            end else if (mem_hit) begin
                src_dat = mem_data;
            end
            // Load data is not ready until MEM, so a load in EX cannot be forwarded.
            hazard = use_src && ex_hit && ex_load;
        end else begin
            hazard = use_src && (ex_hit || mem_hit);
        end
    end

endmodule

// File: rtl/lc3_id_stage_hs.sv
// LC-3 decode stage: operand select with forwarding, immediates, jump targets, IRQ injection.
// Latency: 1 cycle from accepted in_* to registered out_*.
// Backpressure: in_ready drops on hazard, irq, flush or a stalled full output; outputs hold while out_valid && !out_ready.
module lc3_id_stage_hs
    import lc3_pkg::*;
#(
    parameter int          DW     = 16,
    parameter bit          FWD_EN = 1'b1,
    parameter logic [15:0] IRQ_IR = 16'h9000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_ir,
    input  logic [DW-1:0] in_npc,
    input  logic [DW-1:0] psr,
    output logic [2:0]    rf_ra,
    output logic [2:0]    rf_rb,
    input  logic [DW-1:0] rf_da,
    input  logic [DW-1:0] rf_db,
    input  logic          ex_wen,
    input  logic          ex_load,
    input  logic [2:0]    ex_dst,
    input  logic [DW-1:0] ex_data,
    input  logic          mem_wen,
    input  logic [2:0]    mem_dst,
    input  logic [DW-1:0] mem_data,
    input  logic          flush,
    input  logic          irq,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_ir,
    output logic [DW-1:0] out_npc,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [DW-1:0] out_imm,
    output logic [DW-1:0] out_pc,
    output logic          out_cond,
    output logic          out_exc
);

    logic [3:0]    opcode;
    logic [5:0]    fn;
    logic [2:0]    ra_addr;
    logic [2:0]    rb_addr;
    logic          use_a;
    logic          use_b;
    logic          a_is_psr;
    logic          jmp_reg;
    logic          jsr_imm;
    logic          is_exc;
    logic [DW-1:0] imm_v;

    logic [DW-1:0] fwd_a_dat;
    logic [DW-1:0] fwd_b_dat;
    logic          hazard_a;
    logic          hazard_b;
    logic          hazard;

    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [DW-1:0] tgt;

    logic          out_free;
    logic          accept;

    logic          out_valid_q, out_valid_d;
    logic [15:0]   out_ir_q,    out_ir_d;
    logic [DW-1:0] out_npc_q,   out_npc_d;
    logic [DW-1:0] out_a_q,     out_a_d;
    logic [DW-1:0] out_b_q,     out_b_d;
    logic [DW-1:0] out_imm_q,   out_imm_d;
    logic [DW-1:0] out_pc_q,    out_pc_d;
    logic          out_cond_q,  out_cond_d;
    logic          out_exc_q,   out_exc_d;

    assign opcode = in_ir[15:12];
    assign fn     = in_ir[5:0];

    // Decode: which register slots the opcode reads, and its extended immediate.
    always_comb begin
        ra_addr  = in_ir[8:6];
        rb_addr  = in_ir[2:0];
        use_a    = 1'b0;
        use_b    = 1'b0;
        a_is_psr = 1'b0;
        jmp_reg  = 1'b0;
        jsr_imm  = 1'b0;
        is_exc   = 1'b0;
        imm_v    = '0;
        case (opcode)
            OP_ADD, OP_AND: begin
                use_a = 1'b1;
                if (in_ir[5]) begin
                    imm_v = DW'(sext_imm5(in_ir[4:0]));
                end else begin
                    use_b = 1'b1;
                end
            end
            OP_BR, OP_LD, OP_LDI, OP_LEA: begin
                imm_v = DW'(sext_off9(in_ir[8:0]));
            end
            OP_ST, OP_STI: begin
                ra_addr = in_ir[11:9];
                use_a   = 1'b1;
                imm_v   = DW'(sext_off9(in_ir[8:0]));
            end
            OP_JSR: begin
                if (in_ir[11]) begin
                    jsr_imm = 1'b1;
                    imm_v   = DW'(sext_off11(in_ir[10:0]));
                end else begin
                    use_a   = 1'b1;
                    jmp_reg = 1'b1;
                end
            end
            OP_LDR: begin
                use_a = 1'b1;
                imm_v = DW'(sext_off6(in_ir[5:0]));
            end
            OP_STR: begin
                ra_addr = in_ir[11:9];
                rb_addr = in_ir[8:6];
                use_a   = 1'b1;
                use_b   = 1'b1;
                imm_v   = DW'(sext_off6(in_ir[5:0]));
            end
            OP_RTI: begin
                ra_addr = 3'd6;
                use_a   = 1'b1;
            end
            OP_ALU1: begin
                if (fn == FN_NOT) begin
                    use_a = 1'b1;
                end else if (fn == FN_DPS) begin
                    a_is_psr = 1'b1;
                end else if (!in_ir[5]) begin
                    // LS/RS: shift count is unsigned.
                    use_a = 1'b1;
                    imm_v = DW'(in_ir[3:0]);
                end
            end
            OP_JMP: begin
                use_a   = 1'b1;
                jmp_reg = 1'b1;
            end
            OP_EXC: begin
                is_exc = 1'b1;
            end
            OP_TRAP: begin
                imm_v = DW'(in_ir[7:0]);
            end
            default: begin
            end
        endcase
    end

    assign rf_ra = ra_addr;
    assign rf_rb = rb_addr;

    lc3_fwd_mux #(.DW(DW), .FWD_EN(FWD_EN)) u_fwd_a (
        .use_src  (use_a),
        .src      (ra_addr),
        .rf_dat   (rf_da),
        .ex_wen   (ex_wen),
        .ex_load  (ex_load),
        .ex_dst   (ex_dst),
        .ex_data  (ex_data),
        .mem_wen  (mem_wen),
        .mem_dst  (mem_dst),
        .mem_data (mem_data),
        .src_dat  (fwd_a_dat),
        .hazard   (hazard_a)
    );

    lc3_fwd_mux #(.DW(DW), .FWD_EN(FWD_EN)) u_fwd_b (
        .use_src  (use_b),
        .src      (rb_addr),
        .rf_dat   (rf_db),
        .ex_wen   (ex_wen),
        .ex_load  (ex_load),
        .ex_dst   (ex_dst),
        .ex_data  (ex_data),
        .mem_wen  (mem_wen),
        .mem_dst  (mem_dst),
        .mem_data (mem_data),
        .src_dat  (fwd_b_dat),
        .hazard   (hazard_b)
    );

    assign hazard = hazard_a || hazard_b;

    // Final operands: unused slots read as zero; psr bypasses forwarding entirely.
    always_comb begin
        opa = '0;
        if (a_is_psr) begin
            opa = psr;
        end else if (use_a) begin
            opa = fwd_a_dat;
        end
        opb = use_b ? fwd_b_dat : '0;
        tgt = '0;
        if (jsr_imm) begin
            tgt = in_npc + imm_v;
        end else if (jmp_reg) begin
            tgt = opa;
        end
    end

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = reset && !hazard && !irq && !flush && out_free;
    assign accept   = in_valid && in_ready;

    // Output register next state: flush > irq > accept > drain > hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_ir_d    = out_ir_q;
        out_npc_d   = out_npc_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_imm_d   = out_imm_q;
        out_pc_d    = out_pc_q;
        out_cond_d  = out_cond_q;
        out_exc_d   = out_exc_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (irq && out_free) begin
            // The IF instruction stays put and is taken once irq drops.
            out_valid_d = 1'b1;
            out_ir_d    = IRQ_IR;
            out_npc_d   = in_npc;
            out_a_d     = '0;
            out_b_d     = '0;
            out_imm_d   = '0;
            out_pc_d    = '0;
            out_cond_d  = 1'b0;
            out_exc_d   = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_ir_d    = in_ir;
            out_npc_d   = in_npc;
            out_a_d     = opa;
            out_b_d     = opb;
            out_imm_d   = imm_v;
            out_pc_d    = tgt;
            out_cond_d  = jmp_reg || jsr_imm;
            out_exc_d   = is_exc;
        end else if (out_ready) begin
            // Drained with nothing new (also how a hazard bubble is inserted).
            out_valid_d = 1'b0;
        end
    end

    // Output registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_ir_q    <= '0;
            out_npc_q   <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_imm_q   <= '0;
            out_pc_q    <= '0;
            out_cond_q  <= 1'b0;
            out_exc_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ir_q    <= out_ir_d;
            out_npc_q   <= out_npc_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_imm_q   <= out_imm_d;
            out_pc_q    <= out_pc_d;
            out_cond_q  <= out_cond_d;
            out_exc_q   <= out_exc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ir    = out_ir_q;
    assign out_npc   = out_npc_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_imm   = out_imm_q;
    assign out_pc    = out_pc_q;
    assign out_cond  = out_cond_q;
    assign out_exc   = out_exc_q;

endmodule

// File: tb/tb_lc3_id_stage_hs.sv
// Self-checking bench for lc3_id_stage_hs: decode table, handshake corner sequences, random vs. reference model.
// Latency: expects registered outputs one clock after acceptance.
// Backpressure: drives out_ready/irq/flush/hazards and checks in_ready every cycle.
module tb_lc3_id_stage_hs;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_ir;
    logic [DW-1:0] in_npc;
    logic [DW-1:0] psr;
    logic [2:0]    rf_ra;
    logic [2:0]    rf_rb;
    logic [DW-1:0] rf_da;
    logic [DW-1:0] rf_db;
    logic          ex_wen;
    logic          ex_load;
    logic [2:0]    ex_dst;
    logic [DW-1:0] ex_data;
    logic          mem_wen;
    logic [2:0]    mem_dst;
    logic [DW-1:0] mem_data;
    logic          flush;
    logic          irq;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_ir;
    logic [DW-1:0] out_npc;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic [DW-1:0] out_imm;
    logic [DW-1:0] out_pc;
    logic          out_cond;
    logic          out_exc;

    logic [DW-1:0] rf [8];

    always #5 clk = ~clk;

    // External register file: combinational read.
    assign rf_da = rf[rf_ra];
    assign rf_db = rf[rf_rb];

    lc3_id_stage_hs #(.DW(DW), .FWD_EN(1'b1), .IRQ_IR(16'h9000)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ir     (in_ir),
        .in_npc    (in_npc),
        .psr       (psr),
        .rf_ra     (rf_ra),
        .rf_rb     (rf_rb),
        .rf_da     (rf_da),
        .rf_db     (rf_db),
        .ex_wen    (ex_wen),
        .ex_load   (ex_load),
        .ex_dst    (ex_dst),
        .ex_data   (ex_data),
        .mem_wen   (mem_wen),
        .mem_dst   (mem_dst),
        .mem_data  (mem_data),
        .flush     (flush),
        .irq       (irq),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ir    (out_ir),
        .out_npc   (out_npc),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_imm   (out_imm),
        .out_pc    (out_pc),
        .out_cond  (out_cond),
        .out_exc   (out_exc)
    );

    typedef struct {
        logic        valid;
        logic [15:0] ir;
        logic [15:0] npc;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic [15:0] pc;
        logic        cond;
        logic        exc;
    } bundle_t;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic [15:0] pc;
        logic        cond;
        logic        exc;
    } vec_t;

    int      total = 0;
    int      bad   = 0;
    bundle_t m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Sign-extend a bits-wide field to 16 bits using plain integer arithmetic.
    function automatic logic [15:0] sx(input int v, input int bits);
        int t;
        t = v;
        if (t >= (1 << (bits - 1))) t = t - (1 << bits);
        return 16'(t);
    endfunction

    // Value a reader sees for register r: newest in-flight writer first.
    function automatic logic [15:0] regv(input int r);
        if (ex_wen && int'(ex_dst) == r) return ex_data;
        if (mem_wen && int'(mem_dst) == r) return mem_data;
        return rf[r];
    endfunction

    // Architectural meaning of an instruction word: registers read (-1 = none), immediate, control kind.
    task automatic ref_decode(input logic [15:0] ir, output int ar, output int br, output bit apsr,
                              output logic [15:0] imm, output bit jreg, output bit jsr, output bit exc);
        int op;
        int f;
        op = int'(ir[15:12]);
        f  = int'(ir[5:0]);
        ar = -1; br = -1; apsr = 0; imm = 16'h0; jreg = 0; jsr = 0; exc = 0;
        case (op)
            1, 5: begin
                ar = int'(ir[8:6]);
                if (ir[5]) imm = sx(int'(ir[4:0]), 5);
                else br = int'(ir[2:0]);
            end
            0, 2, 10, 14: imm = sx(int'(ir[8:0]), 9);
            3, 11: begin ar = int'(ir[11:9]); imm = sx(int'(ir[8:0]), 9); end
            4: begin
                if (ir[11]) begin jsr = 1; imm = sx(int'(ir[10:0]), 11); end
                else begin ar = int'(ir[8:6]); jreg = 1; end
            end
            6: begin ar = int'(ir[8:6]); imm = sx(int'(ir[5:0]), 6); end
            7: begin ar = int'(ir[11:9]); br = int'(ir[8:6]); imm = sx(int'(ir[5:0]), 6); end
            8: ar = 6;
            9: begin
                if (f == 63) ar = int'(ir[8:6]);
                else if (f == 33) apsr = 1;
                else if (f < 32) begin ar = int'(ir[8:6]); imm = 16'(f % 16); end
            end
            12: begin ar = int'(ir[8:6]); jreg = 1; end
            13: exc = 1;
            15: imm = 16'(int'(ir[7:0]));
            default: ;
        endcase
    endtask

    // Reference next state of the output bundle and expected in_ready for current inputs.
    task automatic model_next(output bundle_t nm, output logic rdy);
        int ar, br;
        bit apsr, jreg, jsr, exc, haz, free;
        logic [15:0] imm, a;
        ref_decode(in_ir, ar, br, apsr, imm, jreg, jsr, exc);
        haz = 0;
        if (ar >= 0 && ex_load && ex_wen && int'(ex_dst) == ar) haz = 1;
        if (br >= 0 && ex_load && ex_wen && int'(ex_dst) == br) haz = 1;
        free = !m.valid || out_ready;
        rdy  = reset && !haz && !irq && !flush && free;
        nm = m;
        if (!reset) begin
            nm = '{default: 0};
        end else if (flush) begin
            nm.valid = 0;
        end else if (irq && free) begin
            nm = '{default: 0};
            nm.valid = 1; nm.ir = 16'h9000; nm.npc = in_npc;
        end else if (in_valid && rdy) begin
            a = apsr ? psr : (ar >= 0 ? regv(ar) : 16'h0);
            nm.valid = 1; nm.ir = in_ir; nm.npc = in_npc; nm.a = a;
            nm.b     = (br >= 0) ? regv(br) : 16'h0;
            nm.imm   = imm;
            nm.pc    = jsr ? 16'(int'(in_npc) + int'(imm)) : (jreg ? a : 16'h0);
            nm.cond  = jsr || jreg;
            nm.exc   = exc;
        end else if (out_ready) begin
            nm.valid = 0;
        end
    endtask

    task automatic chk_outputs();
        chk("out_valid", out_valid, m.valid);
        chk("out_ir",    out_ir,    m.ir);
        chk("out_npc",   out_npc,   m.npc);
        chk("out_a",     out_a,     m.a);
        chk("out_b",     out_b,     m.b);
        chk("out_imm",   out_imm,   m.imm);
        chk("out_pc",    out_pc,    m.pc);
        chk("out_cond",  out_cond,  m.cond);
        chk("out_exc",   out_exc,   m.exc);
    endtask

    // One clock: inputs already driven at the preceding negedge.
    task automatic cycle();
        bundle_t nm;
        logic    rdy;
        #1;
        model_next(nm, rdy);
        chk("in_ready", in_ready, rdy);
        @(posedge clk);
        m = nm;
        @(negedge clk);
        chk_outputs();
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_ir = 16'h0; in_npc = 16'h0; psr = 16'h0;
        ex_wen = 0; ex_load = 0; ex_dst = 3'd0; ex_data = 16'h0;
        mem_wen = 0; mem_dst = 3'd0; mem_data = 16'h0;
        flush = 0; irq = 0; out_ready = 1;
    endtask

    vec_t vt [18];

    initial begin
        // Decode table: rf R0..R7 = 0,5,7,3,0040,1234,BEEF,8000; npc=3001; psr=8002.
        vt[0]  = '{16'h1642, 16'h0005, 16'h0007, 16'h0000, 16'h0000, 1'b0, 1'b0}; // ADD R3,R1,R2
        vt[1]  = '{16'h107F, 16'h0005, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0}; // ADD R0,R1,#-1
        vt[2]  = '{16'h4FFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h3000, 1'b1, 1'b0}; // JSR -1
        vt[3]  = '{16'h55EF, 16'h8000, 16'h0000, 16'h000F, 16'h0000, 1'b0, 1'b0}; // AND R2,R7,#15
        vt[4]  = '{16'h6360, 16'h1234, 16'h0000, 16'hFFE0, 16'h0000, 1'b0, 1'b0}; // LDR R1,R5,#-32
        vt[5]  = '{16'h7985, 16'h0040, 16'hBEEF, 16'h0005, 16'h0000, 1'b0, 1'b0}; // STR R4,R6,#5
        vt[6]  = '{16'h3500, 16'h0007, 16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0}; // ST R2,#-256
        vt[7]  = '{16'hE0FF, 16'h0000, 16'h0000, 16'h00FF, 16'h0000, 1'b0, 1'b0}; // LEA R0,#255
        vt[8]  = '{16'h0FFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0}; // BRnzp #-1
        vt[9]  = '{16'hC140, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 1'b1, 1'b0}; // JMP R5
        vt[10] = '{16'h41C0, 16'h8000, 16'h0000, 16'h0000, 16'h8000, 1'b1, 1'b0}; // JSRR R7
        vt[11] = '{16'h8000, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0}; // RTI
        vt[12] = '{16'hF025, 16'h0000, 16'h0000, 16'h0025, 16'h0000, 1'b0, 1'b0}; // TRAP x25
        vt[13] = '{16'h9021, 16'h8002, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0}; // DPS
        vt[14] = '{16'h92FF, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0}; // NOT R1,R3
        vt[15] = '{16'hD123, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1}; // EXC
        vt[16] = '{16'h94C9, 16'h0003, 16'h0000, 16'h0009, 16'h0000, 1'b0, 1'b0}; // LS R2,R3,#9
        vt[17] = '{16'hA1FE, 16'h0000, 16'h0000, 16'hFFFE, 16'h0000, 1'b0, 1'b0}; // LDI R0,#-2

        rf[0] = 16'h0000; rf[1] = 16'h0005; rf[2] = 16'h0007; rf[3] = 16'h0003;
        rf[4] = 16'h0040; rf[5] = 16'h1234; rf[6] = 16'hBEEF; rf[7] = 16'h8000;
        m = '{default: 0};

        // Reset state.
        idle_inputs();
        reset = 0;
        @(negedge clk);
        cycle();
        cycle();
        chk("reset_valid", out_valid, 0);
        chk("reset_ir", out_ir, 0);
        reset = 1;

        // Decode table.
        for (int i = 0; i < 18; i++) begin
            in_valid = 1; in_ir = vt[i].ir; in_npc = 16'h3001; psr = 16'h8002; out_ready = 1;
            cycle();
            chk("tbl_valid", out_valid, 1);
            chk("tbl_ir",    out_ir,    vt[i].ir);
            chk("tbl_a",     out_a,     vt[i].a);
            chk("tbl_b",     out_b,     vt[i].b);
            chk("tbl_imm",   out_imm,   vt[i].imm);
            chk("tbl_pc",    out_pc,    vt[i].pc);
            chk("tbl_cond",  out_cond,  vt[i].cond);
            chk("tbl_exc",   out_exc,   vt[i].exc);
        end

        // EX wins over MEM for the same register; MEM used when only it matches.
        in_ir = 16'h1642;
        ex_wen = 1; ex_dst = 3'd1; ex_data = 16'd9; mem_wen = 1; mem_dst = 3'd1; mem_data = 16'd4;
        cycle();
        chk("fwd_ex_over_mem", out_a, 16'd9);
        chk("fwd_b_rf", out_b, 16'd7);
        ex_dst = 3'd3; mem_dst = 3'd2;
        cycle();
        chk("fwd_mem_b", out_b, 16'd4);
        chk("fwd_a_rf", out_a, 16'd5);

        // Load-use: one bubble, then accepted once the load leaves EX.
        ex_wen = 1; ex_load = 1; ex_dst = 3'd1; mem_wen = 0;
        #1 chk("loaduse_rdy", in_ready, 0);
        cycle();
        chk("loaduse_bubble", out_valid, 0);
        ex_wen = 0; ex_load = 0;
        cycle();
        chk("loaduse_accept", out_valid, 1);
        chk("loaduse_a", out_a, 16'd5);

        // Output stall for three cycles: everything holds, nothing accepted.
        out_ready = 0; in_ir = 16'h107F; in_npc = 16'h4000;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_rdy", in_ready, 0);
            cycle();
            chk("stall_ir", out_ir, 16'h1642);
            chk("stall_a", out_a, 16'd5);
            chk("stall_valid", out_valid, 1);
        end

        // IRQ with output free: inject, keep the IF instruction pending.
        out_ready = 1; irq = 1;
        cycle();
        chk("irq_ir", out_ir, 16'h9000);
        chk("irq_npc", out_npc, 16'h4000);
        chk("irq_a", out_a, 0);
        irq = 0;
        cycle();
        chk("irq_pending_ir", out_ir, 16'h107F);

        // flush and irq together: flush wins, irq taken the next cycle.
        flush = 1; irq = 1;
        cycle();
        chk("flush_valid", out_valid, 0);
        flush = 0;
        cycle();
        chk("irq_after_flush", out_ir, 16'h9000);

        // Reset while stalled clears everything.
        irq = 0; out_ready = 0; reset = 0;
        #1 chk("reset_rdy", in_ready, 0);
        cycle();
        chk("rst_valid", out_valid, 0);
        chk("rst_ir", out_ir, 0);
        chk("rst_npc", out_npc, 0);
        reset = 1; out_ready = 1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 7) == 0)
                    in_ir = {4'h9, 6'($urandom), ($urandom_range(0, 1) ? 6'd33 : 6'd63)};
                else
                    in_ir = 16'($urandom);
                in_npc = 16'($urandom);
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            psr       = 16'($urandom);
            for (int r = 0; r < 8; r++) rf[r] = 16'($urandom);
            ex_wen    = $urandom_range(0, 1) == 1;
            ex_load   = $urandom_range(0, 3) == 0;
            ex_dst    = 3'($urandom);
            ex_data   = 16'($urandom);
            mem_wen   = $urandom_range(0, 1) == 1;
            mem_dst   = 3'($urandom);
            mem_data  = 16'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 15) == 0;
            irq       = $urandom_range(0, 15) == 0;
            reset     = $urandom_range(0, 49) != 0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lc3_id_stage_hs.md
Name: lc3_id_stage_hs

Overview:
Parametrised, handshaked successor to the LC-3 pipeline decode stage. It decodes a 16-bit LC-3 instruction, selects source operands, sign-extends immediates to DW bits and resolves JMP/JSR/JSRR targets. It adds EX/MEM forwarding, load-use stall detection, valid/ready flow control, flush and registered IRQ injection. It sits between IF and EX and reads an external 8-entry register file through two combinational read ports.

Parameters:
DW, 16, data/address width; immediates and PC targets are sign- or zero-extended to DW.
FWD_EN, 1, 1 = forward from EX/MEM; 0 = stall on any EX/MEM destination match.
IRQ_IR, 16'h9000, instruction word injected into out_ir on an accepted interrupt.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset.
in_valid  in  1  IF holds a valid instruction.
in_ready  out  1  ID accepts the instruction this cycle (combinational).
in_ir  in  16  instruction word.
in_npc  in  DW  PC+1 of in_ir.
psr  in  DW  processor status word; source for DPS.
rf_ra / rf_rb  out  3 each  register-file read addresses (combinational from in_ir).
rf_da / rf_db  in  DW each  register-file read data, same cycle.
ex_wen, ex_load  in  1 each  EX writes a register / EX instruction is a load.
ex_dst  in  3  EX destination register.
ex_data  in  DW  EX result.
mem_wen  in  1  MEM writes a register.
mem_dst  in  3  MEM destination register.
mem_data  in  DW  MEM result.
flush  in  1  kill the in-flight and held instruction (branch taken).
irq  in  1  interrupt request.
out_valid  out  1  decoded bundle valid.
out_ready  in  1  EX accepts the bundle.
out_ir  out  16  registered instruction.
out_npc  out  DW  registered PC+1.
out_a, out_b, out_imm, out_pc  out  DW each  operand A, operand B, extended immediate, jump target.
out_cond  out  1  unconditional control transfer (JMP/JSR/JSRR).
out_exc  out  1  illegal/EXC opcode (4'b1101).

Behaviour:
- Reset (reset==0 at a rising edge): every output register is 0, including out_valid, out_ir, out_exc and out_cond. in_ready is 0 while reset is low.
- Latency: 1 cycle. An instruction accepted at edge N appears on the out_* registers after edge N.
- Operand sources:
  - ADD/AND/NOT/LDR/JMP/JSRR: A = SR1 [8:6].
  - ADD/AND register mode: B = SR2 [2:0].
  - ST/STI/STR: A = SR [11:9]; STR: B = BaseR [8:6].
  - RTI: A = R6.
  - DPS (1001, [5:0]=100001): A = psr.
- Immediates, sign-extended to DW:
  - imm5 for ADD/AND immediate mode.
  - off6 for LDR/STR.
  - off9 for BR/LD/LDI/LEA/ST/STI.
  - off11 for JSR.
  - trapvect8 zero-extended.
  - shift imm4 zero-extended for LS/RS.
- Jump targets: JMP/JSRR out_pc = forwarded A. JSR out_pc = in_npc + sext(off11), modulo 2^DW.
- Undefined opcode: out_a/out_b/out_imm are 0.
- Forwarding (FWD_EN=1), per source: EX match (ex_wen && ex_dst==src) wins over MEM match, which wins over rf data. R6 for RTI is forwarded the same way. psr is never forwarded.
- Hazard, computed only over sources the opcode actually uses:
  - FWD_EN=1: ex_load && ex_wen && ex_dst==src.
  - FWD_EN=0: any EX or MEM write matching a used source.
- in_ready = reset && !hazard && !irq && !flush && (!out_valid || out_ready).
- On hazard with the output free: load a bubble (out_valid=0) and hold the IF instruction.
- Output update priority, highest first:
  1. reset.
  2. flush: out_valid<=0; nothing accepted.
  3. irq with the output free: out_ir<=IRQ_IR, out_npc<=in_npc, out_valid<=1, other outputs 0; the IF instruction is not consumed.
  4. accept.
  5. out_ready: out_valid<=0.
  6. hold.
- While out_valid && !out_ready, every out_* register holds stable.
- out_exc is a registered level for the accepted EXC instruction. It is not clock-derived.
- flush and irq in the same cycle: flush wins; irq is re-sampled next cycle.

Decomposition:
- Package lc3_pkg: opcode localparams (OP_ADD=4'b0001 … OP_TRAP=4'b1111, OP_EXC=4'b1101) and sext helper functions (imm5/off6/off9/off11 to DW).
- Sub-module lc3_fwd_mux: one instance per source. Handles the EX/MEM/RF select and the per-source hazard bit.

Test Plan:
- ADD R3,R1,R2 with rf R1=5, R2=7, no forwarding → one cycle later out_valid=1, out_a=5, out_b=7, out_ir=16'h1642.
- ADD R0,R1,#-1 (16'h107F) → out_imm=16'hFFFF; JSR with off11=11'h7FF and in_npc=16'h3001 → out_pc=16'h3000, out_cond=1.
- ex_wen=1, ex_dst=1, ex_data=9 and mem_wen=1, mem_dst=1, mem_data=4; decode ADD R3,R1,R2 → out_a=9 (EX over MEM).
- ex_load=1, ex_dst=1, decode ADD R3,R1,R2 → in_ready=0, one bubble (out_valid=0), accepted the next cycle once ex_load drops.
- out_ready=0 for 3 cycles after a valid bundle → outputs stable, in_ready=0. irq=1 with output free → out_ir=16'h9000, IF instruction still pending.
- flush and irq asserted together, then reset=0 mid-stall → out_valid=0 next cycle; after reset all outputs are 0.
